if_stage: RTL and testbench

Instruction-fetch stage that sits directly upstream of the decode stage. It owns the PC and a pre-IF next-PC generator, and drives the synchronous instruction SRAM, whose read data returns one cycle after the address. It delivers {pc, inst} to decode over the valid/allow_in handshake. A one-entry instruction buffer keeps the fetched word stable while decode stalls, and branch redirects from decode cancel the in-flight fetch.

---
 rtl/if_stage_pkg.sv | 15 +
 rtl/if_inst_buffer.sv | 28 ++
 rtl/if_stage.sv | 105 ++++++++++
 tb/tb_if_stage.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: bus widths, reset PC and
// the sequential-PC helper.
package if_stage_pkg;

    localparam int IF_TO_ID_BUS_WIDTH = 64;
    localparam int ID_TO_IF_BUS_WIDTH = 34;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h1c00_0000;

    // Next sequential fetch address; 32-bit modulo, so 0xFFFFFFFC wraps to 0.
    function automatic logic [31:0] seq_pc_of(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/if_inst_buffer.sv
// One-entry holding register that keeps the fetched word stable while decode
// stalls; clear has priority over capture.
module if_inst_buffer (
    input  logic        clk,
    input  logic        reset,
    input  logic        capture,
    input  logic        clear,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        valid
);

    // Holding register and its valid flag; the data is left as-is on clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dout  <= 32'd0;
            valid <= 1'b0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (capture) begin
            dout  <= din;
            valid <= 1'b1;
        end else begin
            valid <= valid;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives the synchronous instruction SRAM
// and hands {pc, inst} to decode. Optional counters under IF_PERF_CNT_EN.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          id_allow_in,
    output logic                          if_to_id_valid,
    input  logic [ID_TO_IF_BUS_WIDTH-1:0] id_to_if_bus,
    output logic [IF_TO_ID_BUS_WIDTH-1:0] if_to_id_bus,
    output logic                          inst_sram_en,
    output logic [3:0]                    inst_sram_we,
    output logic [31:0]                   inst_sram_addr,
    output logic [31:0]                   inst_sram_wdata,
    input  logic [31:0]                   inst_sram_rdata
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]                   fetch_cnt,
    output logic [31:0]                   stall_cnt
`endif
);

    logic        br_taken_s;
    logic [31:0] br_target_s;
    logic        unused_br_cancel_s;
    logic        pre_valid_r;
    logic        if_valid_r;
    logic [31:0] if_pc_r;
    logic [31:0] nextpc_s;
    logic        if_allow_in_s;
    logic        load_s;
    logic        capture_s;
    logic [31:0] inst_buf_s;
    logic        buf_valid_s;
    logic [31:0] if_inst_s;

    // br_taken_cancel is decode's own kill and has no effect on fetch.
    assign br_taken_s         = id_to_if_bus[33];
    assign br_target_s        = id_to_if_bus[32:1];
    assign unused_br_cancel_s = id_to_if_bus[0];

    assign nextpc_s      = br_taken_s ? br_target_s : seq_pc_of(if_pc_r);
    assign if_allow_in_s = !if_valid_r || id_allow_in;
    // A redirect fetches its target even while decode is stalled.
    assign load_s        = pre_valid_r && (if_allow_in_s || br_taken_s);
    assign capture_s     = if_valid_r && !buf_valid_s && !id_allow_in && !br_taken_s;

    // Pre-IF becomes valid on the first edge after reset release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pre_valid_r <= 1'b0;
        end else begin
            pre_valid_r <= 1'b1;
        end
    end

    // IF-stage PC and valid; RESET_PC-4 makes the first sequential fetch RESET_PC.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            if_valid_r <= 1'b0;
            if_pc_r    <= RESET_PC - 32'd4;
        end else if (load_s) begin
            if_valid_r <= 1'b1;
            if_pc_r    <= nextpc_s;
        end else begin
            if_valid_r <= if_valid_r;
            if_pc_r    <= if_pc_r;
        end
    end

    if_inst_buffer u_inst_buffer (
        .clk     (clk),
        .reset   (reset),
        .capture (capture_s),
        .clear   (load_s),
        .din     (inst_sram_rdata),
        .dout    (inst_buf_s),
        .valid   (buf_valid_s)
    );

    assign if_inst_s       = buf_valid_s ? inst_buf_s : inst_sram_rdata;
    assign if_to_id_valid  = if_valid_r && !br_taken_s;
    assign if_to_id_bus    = {if_pc_r, if_inst_s};
    assign inst_sram_en    = load_s;
    assign inst_sram_we    = 4'b0000;
    assign inst_sram_addr  = nextpc_s;
    assign inst_sram_wdata = 32'd0;

`ifdef IF_PERF_CNT_EN
    // Accepted handoffs and decode-stall cycles, both wrapping at 2^32.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_cnt <= 32'd0;
            stall_cnt <= 32'd0;
        end else begin
            fetch_cnt <= fetch_cnt + {31'd0, (if_to_id_valid && id_allow_in)};
            stall_cnt <= stall_cnt + {31'd0, (if_valid_r && !id_allow_in && !br_taken_s)};
        end
    end
`endif

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios plus random traffic,
// compared against a transaction-level model where the held word equals its PC.
module tb_if_stage;

    logic        clk;
    logic        reset;
    logic        id_allow_in;
    logic        if_to_id_valid;
    logic [33:0] id_to_if_bus;
    logic [63:0] if_to_id_bus;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_we;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata;
`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt;
    logic [31:0] stall_cnt;
`endif

    int n_cmp;
    int n_err;

    // model: what IF should hold, in terms of fetched addresses
    logic        m_pre;
    logic        m_valid;
    logic [31:0] m_pc;
    logic [31:0] m_fetch;
    logic [31:0] m_stall;
    logic [31:0] handoffs[$];

    if_stage #(.RESET_PC(32'h1c00_0000)) dut (
        .clk             (clk),
        .reset           (reset),
        .id_allow_in     (id_allow_in),
        .if_to_id_valid  (if_to_id_valid),
        .id_to_if_bus    (id_to_if_bus),
        .if_to_id_bus    (if_to_id_bus),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_we    (inst_sram_we),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_wdata (inst_sram_wdata),
        .inst_sram_rdata (inst_sram_rdata)
`ifdef IF_PERF_CNT_EN
        ,
        .fetch_cnt       (fetch_cnt),
        .stall_cnt       (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM returns the address as data; junk whenever no read was enabled.
    always @(posedge clk) begin
        if (inst_sram_en) inst_sram_rdata <= inst_sram_addr;
        else              inst_sram_rdata <= $urandom;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pre   = 1'b0;
        m_valid = 1'b0;
        m_pc    = 32'h1bff_fffc;
        m_fetch = 32'd0;
        m_stall = 32'd0;
    endtask

    task automatic step(input logic allow, input logic br, input logic [31:0] tgt);
        logic        exp_vld;
        logic        exp_en;
        logic [31:0] exp_addr;
        @(negedge clk);
        id_allow_in  = allow;
        id_to_if_bus = {br, tgt, 1'($urandom)};
        #1;
        exp_vld  = m_valid && !br;
        exp_addr = br ? tgt : m_pc + 32'd4;
        exp_en   = reset && m_pre && (!m_valid || allow || br);
        check("valid", {63'd0, if_to_id_valid}, {63'd0, exp_vld});
        check("en", {63'd0, inst_sram_en}, {63'd0, exp_en});
        check("addr", {32'd0, inst_sram_addr}, {32'd0, exp_addr});
        check("pc", {32'd0, if_to_id_bus[63:32]}, {32'd0, m_pc});
        if (m_valid) check("inst", {32'd0, if_to_id_bus[31:0]}, {32'd0, m_pc});
        check("we_wdata", {28'd0, inst_sram_we, inst_sram_wdata}, 64'd0);
`ifdef IF_PERF_CNT_EN
        check("fetch_cnt", {32'd0, fetch_cnt}, {32'd0, m_fetch});
        check("stall_cnt", {32'd0, stall_cnt}, {32'd0, m_stall});
`endif
        if (if_to_id_valid && allow) handoffs.push_back(if_to_id_bus[63:32]);
        @(posedge clk);
        if (reset) begin
            m_fetch = m_fetch + ((exp_vld && allow) ? 32'd1 : 32'd0);
            m_stall = m_stall + ((m_valid && !allow && !br) ? 32'd1 : 32'd0);
            if (exp_en) begin
                m_valid = 1'b1;
                m_pc    = exp_addr;
            end
            m_pre = 1'b1;
        end
        #1;
    endtask

    initial begin
        logic [31:0] tgt;
        n_cmp        = 0;
        n_err        = 0;
        reset        = 1'b0;
        id_allow_in  = 1'b0;
        id_to_if_bus = 34'd0;
        model_reset();

        step(1'b1, 1'b0, 32'd0);
        step(1'b1, 1'b0, 32'd0);
        id_to_if_bus = 34'd0;
        #2 reset = 1'b1;
        #1 check("first_addr", {32'd0, inst_sram_addr}, 64'h1c00_0000);

        // sequential fetch, then a 3-cycle decode stall at 0x1c000008
        handoffs.delete();
        repeat (4) step(1'b1, 1'b0, 32'd0);
        repeat (3) step(1'b0, 1'b0, 32'd0);
        repeat (2) step(1'b1, 1'b0, 32'd0);
        check("seq0", {32'd0, handoffs[0]}, 64'h1c00_0000);
        check("seq1", {32'd0, handoffs[1]}, 64'h1c00_0004);
        check("seq2", {32'd0, handoffs[2]}, 64'h1c00_0008);
        check("resume", {32'd0, handoffs[3]}, 64'h1c00_000c);

        // branch with decode accepting: held word is dropped
        handoffs.delete();
        step(1'b1, 1'b1, 32'h1c00_0100);
        step(1'b1, 1'b0, 32'd0);
        step(1'b1, 1'b0, 32'd0);
        check("br_count", {32'd0, 32'(handoffs.size())}, 64'd2);
        check("br_tgt", {32'd0, handoffs[0]}, 64'h1c00_0100);
        check("br_next", {32'd0, handoffs[1]}, 64'h1c00_0104);

        // branch during a stall with the buffer already full
        step(1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b1, 32'h1c00_0200);
        handoffs.delete();
        step(1'b1, 1'b0, 32'd0);
        check("br_stall", {32'd0, handoffs[0]}, 64'h1c00_0200);

        // PC wrap
        step(1'b1, 1'b1, 32'hffff_fffc);
        id_to_if_bus = 34'd0;
        #1 check("wrap", {32'd0, inst_sram_addr}, 64'd0);
        repeat (2) step(1'b1, 1'b0, 32'd0);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            tgt = $urandom & 32'hffff_fffc;
            step(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) == 0), tgt);
        end

        // asynchronous reset pulsed mid-stall
        step(1'b1, 1'b0, 32'd0);
        step(1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 32'd0);
        #2 reset = 1'b0;
        #1;
        check("rst_valid", {63'd0, if_to_id_valid}, 64'd0);
        check("rst_en", {63'd0, inst_sram_en}, 64'd0);
        model_reset();
`ifdef IF_PERF_CNT_EN
        check("rst_fetch_cnt", {32'd0, fetch_cnt}, 64'd0);
        check("rst_stall_cnt", {32'd0, stall_cnt}, 64'd0);
`endif
        step(1'b0, 1'b0, 32'd0);
        #2 reset = 1'b1;
        handoffs.delete();
        repeat (5) step(1'b1, 1'b0, 32'd0);
        check("restart0", {32'd0, handoffs[0]}, 64'h1c00_0000);
        check("restart1", {32'd0, handoffs[1]}, 64'h1c00_0004);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
